// File: rtl/rv32_mod_bus_arbiter_if.sv
// Signal bundle between the hart's fetch/data ports, the arbiter and the external bus.
// master: the arbiter's view; slave: the view of whatever surrounds the arbiter.
interface rv32_mod_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    logic [1:0]  grant;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  bus_ack, bus_err, bus_rdata,
        output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata, grant
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output bus_ack, bus_err, bus_rdata,
        input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata, grant
    );
endinterface

// File: rtl/rv32_mod_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and load/store,
// with a per-transaction timeout that forces an error so a hung slave cannot stall the hart.
module rv32_mod_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input logic                    clk,
    input logic                    reset_n,
    rv32_mod_bus_arbiter_if.master bif
);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    localparam logic LastInstr = 1'b0;
    localparam logic LastData  = 1'b1;
    localparam logic [CNT_W-1:0] TimeoutLast =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic sel_d;
    logic gnt_req;
    logic timeout;
    logic resp_ack;
    logic resp_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= LastInstr;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_d   = (state_q == StGntD);
    assign gnt_req = sel_d ? bif.d_req : bif.i_req;
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        resp_ack      = 1'b0;
        resp_err      = 1'b0;
        bif.bus_req   = 1'b0;
        bif.bus_we    = 1'b0;
        bif.bus_be    = 4'h0;
        bif.bus_addr  = 32'h0;
        bif.bus_wdata = 32'h0;
        bif.grant     = 2'b00;

        unique case (state_q)
            StIdle: begin
                // Both requesting: grant whichever port did not win last time.
                if (bif.d_req && (!bif.i_req || last_q == LastInstr)) begin
                    state_d = StGntD;
                    last_d  = LastData;
                    cnt_d   = '0;
                end else if (bif.i_req) begin
                    state_d = StGntI;
                    last_d  = LastInstr;
                    cnt_d   = '0;
                end
            end
            StGntI, StGntD: begin
                bif.bus_req   = 1'b1;
                bif.grant     = sel_d ? 2'b10 : 2'b01;
                bif.bus_we    = sel_d ? bif.d_we    : 1'b0;
                bif.bus_be    = sel_d ? bif.d_be    : 4'hF;
                bif.bus_addr  = sel_d ? bif.d_addr  : bif.i_addr;
                bif.bus_wdata = sel_d ? bif.d_wdata : 32'h0;
                // A dropped request is an abort: leave silently.
                if (!gnt_req) begin
                    state_d = StIdle;
                end else if (bif.bus_err || (!bif.bus_ack && timeout)) begin
                    resp_err = 1'b1;
                    state_d  = StIdle;
                end else if (bif.bus_ack) begin
                    resp_ack = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bif.i_ack   = resp_ack && !sel_d;
        bif.i_err   = resp_err && !sel_d;
        bif.i_rdata = (resp_ack && !sel_d) ? bif.bus_rdata : 32'h0;
        bif.d_ack   = resp_ack && sel_d;
        bif.d_err   = resp_err && sel_d;
        bif.d_rdata = (resp_ack && sel_d) ? bif.bus_rdata : 32'h0;
    end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Directed bench for rv32_mod_bus_arbiter: fetch, round-robin, store, timeout,
// ack+err collision, asynchronous reset and abort.
module tb_rv32_mod_bus_arbiter;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    rv32_mod_bus_arbiter_if bif ();

    rv32_mod_bus_arbiter #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bif    (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bif.i_req     = 1'b0;
        bif.i_addr    = 32'h0;
        bif.d_req     = 1'b0;
        bif.d_we      = 1'b0;
        bif.d_be      = 4'h0;
        bif.d_addr    = 32'h0;
        bif.d_wdata   = 32'h0;
        bif.bus_ack   = 1'b0;
        bif.bus_err   = 1'b0;
        bif.bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        clear_inputs();
        #2;
        chk("rst_grant", {30'h0, bif.grant}, 32'h0);
        chk("rst_bus_req", {31'h0, bif.bus_req}, 32'h0);
        chk("rst_bus_addr", bif.bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, bif.bus_be}, 32'h0);
        chk("rst_acks", {28'h0, bif.i_ack, bif.i_err, bif.d_ack, bif.d_err}, 32'h0);
        step();
        reset_n = 1'b1;

        // Single fetch, zero-wait slave.
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h100;
        #1;
        chk("t1_idle_grant", {30'h0, bif.grant}, 32'h0);
        chk("t1_idle_bus_req", {31'h0, bif.bus_req}, 32'h0);
        step();
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h0000_0013;
        #1;
        chk("t1_bus_req", {31'h0, bif.bus_req}, 32'h1);
        chk("t1_bus_addr", bif.bus_addr, 32'h100);
        chk("t1_bus_be", {28'h0, bif.bus_be}, 32'hF);
        chk("t1_bus_we", {31'h0, bif.bus_we}, 32'h0);
        chk("t1_grant", {30'h0, bif.grant}, 32'h1);
        chk("t1_i_ack", {31'h0, bif.i_ack}, 32'h1);
        chk("t1_i_rdata", bif.i_rdata, 32'h13);
        chk("t1_d_ack", {31'h0, bif.d_ack}, 32'h0);
        step();
        bif.i_req   = 1'b0;
        bif.bus_ack = 1'b0;
        #1;
        chk("t1_back_idle", {30'h0, bif.grant}, 32'h0);
        chk("t1_bus_req_low", {31'h0, bif.bus_req}, 32'h0);

        // Both ports held from reset, slave always acks: D, I, D.
        do_reset();
        bif.i_req     = 1'b1;
        bif.i_addr    = 32'h200;
        bif.d_req     = 1'b1;
        bif.d_be      = 4'hF;
        bif.d_addr    = 32'h300;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'h0000_AAAA;
        #1;
        chk("t2_c0_grant", {30'h0, bif.grant}, 32'h0);
        chk("t2_c0_ignored_ack", {30'h0, bif.i_ack, bif.d_ack}, 32'h0);
        step();
        chk("t2_c1_grant", {30'h0, bif.grant}, 32'h2);
        chk("t2_c1_addr", bif.bus_addr, 32'h300);
        chk("t2_c1_acks", {30'h0, bif.i_ack, bif.d_ack}, 32'h1);
        chk("t2_c1_d_rdata", bif.d_rdata, 32'hAAAA);
        chk("t2_c1_i_rdata", bif.i_rdata, 32'h0);
        step();
        chk("t2_c2_grant", {30'h0, bif.grant}, 32'h0);
        chk("t2_c2_acks", {30'h0, bif.i_ack, bif.d_ack}, 32'h0);
        step();
        chk("t2_c3_grant", {30'h0, bif.grant}, 32'h1);
        chk("t2_c3_addr", bif.bus_addr, 32'h200);
        chk("t2_c3_acks", {30'h0, bif.i_ack, bif.d_ack}, 32'h2);
        chk("t2_c3_d_rdata", bif.d_rdata, 32'h0);
        step();
        chk("t2_c4_grant", {30'h0, bif.grant}, 32'h0);
        step();
        chk("t2_c5_grant", {30'h0, bif.grant}, 32'h2);
        chk("t2_c5_acks", {30'h0, bif.i_ack, bif.d_ack}, 32'h1);
        step();
        clear_inputs();

        // Store: fields pass through unchanged, ack one cycle later.
        bif.d_req   = 1'b1;
        bif.d_we    = 1'b1;
        bif.d_be    = 4'b0011;
        bif.d_addr  = 32'h2000;
        bif.d_wdata = 32'hDEAD_BEEF;
        step();
        chk("t3_grant", {30'h0, bif.grant}, 32'h2);
        chk("t3_bus_we", {31'h0, bif.bus_we}, 32'h1);
        chk("t3_bus_be", {28'h0, bif.bus_be}, 32'h3);
        chk("t3_bus_addr", bif.bus_addr, 32'h2000);
        chk("t3_bus_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
        chk("t3_no_ack_yet", {31'h0, bif.d_ack}, 32'h0);
        bif.bus_ack = 1'b1;
        #1;
        chk("t3_d_ack", {31'h0, bif.d_ack}, 32'h1);
        chk("t3_i_ack", {31'h0, bif.i_ack}, 32'h0);
        step();
        clear_inputs();
        #1;
        chk("t3_d_ack_pulse", {31'h0, bif.d_ack}, 32'h0);

        // Silent slave: forced error in the 16th granted cycle.
        bif.d_req  = 1'b1;
        bif.d_addr = 32'h3000;
        bif.d_be   = 4'hF;
        step();
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("t4_d_err_cyc%0d", k), {31'h0, bif.d_err}, (k == 16) ? 32'h1 : 32'h0);
            if (k == 1 || k == 16) chk($sformatf("t4_bus_req_cyc%0d", k), {31'h0, bif.bus_req}, 32'h1);
            if (k < 16) step();
        end
        step();
        bif.d_req   = 1'b0;
        bif.bus_ack = 1'b1;
        #1;
        chk("t4_bus_req_dropped", {31'h0, bif.bus_req}, 32'h0);
        chk("t4_late_ack_ignored", {30'h0, bif.d_ack, bif.d_err}, 32'h0);
        step();
        clear_inputs();

        // ack and err together: err wins.
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h400;
        step();
        bif.bus_ack = 1'b1;
        bif.bus_err = 1'b1;
        #1;
        chk("t5_i_err", {31'h0, bif.i_err}, 32'h1);
        chk("t5_i_ack", {31'h0, bif.i_ack}, 32'h0);
        chk("t5_d_err", {31'h0, bif.d_err}, 32'h0);
        step();
        clear_inputs();
        #1;
        chk("t5_i_err_pulse", {31'h0, bif.i_err}, 32'h0);

        // Asynchronous reset mid-grant.
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h480;
        step();
        chk("t5_pre_rst_bus_req", {31'h0, bif.bus_req}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_bus_req", {31'h0, bif.bus_req}, 32'h0);
        chk("t5_rst_grant", {30'h0, bif.grant}, 32'h0);
        clear_inputs();
        step();
        reset_n = 1'b1;

        // Abort: d_req drops in 2nd granted cycle, waiting fetch follows.
        bif.d_req  = 1'b1;
        bif.d_addr = 32'h5000;
        step();
        chk("t6_grant_d", {30'h0, bif.grant}, 32'h2);
        step();
        bif.d_req  = 1'b0;
        bif.i_req  = 1'b1;
        bif.i_addr = 32'h500;
        #1;
        chk("t6_abort_silent", {28'h0, bif.i_ack, bif.i_err, bif.d_ack, bif.d_err}, 32'h0);
        step();
        chk("t6_idle", {30'h0, bif.grant}, 32'h0);
        chk("t6_idle_d_err", {31'h0, bif.d_err}, 32'h0);
        step();
        chk("t6_grant_i", {30'h0, bif.grant}, 32'h1);
        chk("t6_bus_addr", bif.bus_addr, 32'h500);
        bif.bus_ack = 1'b1;
        #1;
        chk("t6_i_ack", {31'h0, bif.i_ack}, 32'h1);
        step();
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
